// File: rtl/conv_result_streamer_if.sv
// Byte-stream handshake bundle carrying the unpacked conv result.
interface conv_result_streamer_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned IDX_W = 7
);
    logic             valid;
    logic             ready;
    logic [W-1:0]     data;
    logic [IDX_W-1:0] idx;
    logic             last;

    modport master (output valid, data, idx, last, input ready);
    modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: snapshots the flattened conv result vector and
// streams it out byte by byte (byte 0 first) over a valid/ready handshake.
// Optional feature macro STREAM_CHKSUM_EN appends a mod-2^W byte checksum
// as one extra byte with idx = N_BYTES.
module conv_result_streamer #(
    parameter int unsigned N_BYTES = 108,
    parameter int unsigned W       = 8,
    parameter int unsigned IDX_W   = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_BYTES*W-1:0]   conv_lin,
    output logic                   busy,
    output logic                   done,
    conv_result_streamer_if.master out
);

    localparam int unsigned VEC_W = N_BYTES * W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
`ifdef STREAM_CHKSUM_EN
    localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(N_BYTES);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, CHK = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
`endif

    state_t           state_q, state_d;
    // Bytes not yet presented; shifted down one byte per transfer.
    logic [VEC_W-1:0] cap_q, cap_d;
    logic [W-1:0]     data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef STREAM_CHKSUM_EN
    logic [W-1:0]     sum_q, sum_d;
`endif

    logic xfer_c;
    assign xfer_c = valid_q & out.ready;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef STREAM_CHKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef STREAM_CHKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef STREAM_CHKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_d   = conv_lin >> W;
                    data_d  = conv_lin[W-1:0];
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = 1'b0;
                    state_d = STREAM;
                end
            end

            STREAM: begin
                if (xfer_c) begin
`ifdef STREAM_CHKSUM_EN
                    sum_d = sum_q + data_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef STREAM_CHKSUM_EN
                        data_d  = sum_q + data_q;
                        idx_d   = CHK_IDX;
                        last_d  = 1'b1;
                        state_d = CHK;
`else
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        data_d = cap_q[W-1:0];
                        cap_d  = cap_q >> W;
                        idx_d  = idx_q + IDX_W'(1);
`ifdef STREAM_CHKSUM_EN
                        last_d = 1'b0;
`else
                        last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
`endif
                    end
                end
            end

`ifdef STREAM_CHKSUM_EN
            CHK: begin
                if (xfer_c) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = '0;
                    state_d = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    assign out.valid = valid_q;
    assign out.data  = data_q;
    assign out.idx   = idx_q;
    assign out.last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized bench for conv_result_streamer with a queue-based frame model.
module tb_conv_result_streamer;

    localparam int unsigned N_BYTES = 108;
    localparam int unsigned W       = 8;
    localparam int unsigned IDX_W   = 7;
`ifdef STREAM_CHKSUM_EN
    localparam int unsigned CHK_BYTES = 1;
`else
    localparam int unsigned CHK_BYTES = 0;
`endif
    localparam int unsigned FRAME_LEN = N_BYTES + CHK_BYTES;

    typedef logic [N_BYTES*W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    vec_t conv_lin = '0;
    logic busy;
    logic done;

    conv_result_streamer_if #(.W(W), .IDX_W(IDX_W)) sif();

    conv_result_streamer #(.N_BYTES(N_BYTES), .W(W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .conv_lin (conv_lin),
        .busy     (busy),
        .done     (done),
        .out      (sif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]     exp_q[$];
    int               rx = 0;
    bit               act = 1'b0;
    bit               done_exp = 1'b0;
    int               frames_done = 0;
    int               cyc = 0;
    int               start_cyc = 0;
    int               done_cyc = 0;
    bit               prev_stall = 1'b0;
    logic [W-1:0]     prev_data;
    logic [IDX_W-1:0] prev_idx;
    logic             prev_last;
    logic [W-1:0]     last_data;
    int               last_idx;
    int               ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < int'(N_BYTES); i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic vec_t ramp_vec();
        vec_t v;
        for (int i = 0; i < int'(N_BYTES); i++) v[i*W +: W] = W'(i);
        return v;
    endfunction

    function automatic vec_t const_vec(input logic [W-1:0] b);
        vec_t v;
        for (int i = 0; i < int'(N_BYTES); i++) v[i*W +: W] = b;
        return v;
    endfunction

    // One clock: drive ready, check at negedge, advance the model, return at posedge+1.
    task automatic cycle();
        bit act0;
        logic [W-1:0] sum;
        case (ready_mode)
            0:       sif.ready = 1'b1;
            1:       sif.ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: sif.ready = 1'($urandom % 2);
        endcase
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            act0 = act;
            check("valid", 32'(sif.valid), 32'(act));
            check("busy", 32'(busy), 32'(act));
            check("done", 32'(done), 32'(done_exp));
            if (done_exp) begin
                frames_done++;
                done_cyc = cyc;
            end
            done_exp = 1'b0;
            if (prev_stall) begin
                check("hold_data", 32'(sif.data), 32'(prev_data));
                check("hold_idx", 32'(sif.idx), 32'(prev_idx));
                check("hold_last", 32'(sif.last), 32'(prev_last));
            end
            prev_stall = sif.valid && !sif.ready;
            prev_data  = sif.data;
            prev_idx   = sif.idx;
            prev_last  = sif.last;
            if (sif.valid && sif.ready && act && exp_q.size() > 0) begin
                check("data", 32'(sif.data), 32'(exp_q[0]));
                check("idx", 32'(sif.idx), 32'(rx));
                check("last", 32'(sif.last), 32'(exp_q.size() == 1));
                if (exp_q.size() == 1) begin
                    last_data = sif.data;
                    last_idx  = int'(sif.idx);
                end
                void'(exp_q.pop_front());
                rx++;
                if (exp_q.size() == 0) begin
                    act = 1'b0;
                    done_exp = 1'b1;
                end
            end
            if (start && !act0) begin
                exp_q.delete();
                sum = '0;
                for (int i = 0; i < int'(N_BYTES); i++) begin
                    exp_q.push_back(conv_lin[i*W +: W]);
                    sum = sum + conv_lin[i*W +: W];
                end
                if (CHK_BYTES != 0) exp_q.push_back(sum);
                act = 1'b1;
                rx = 0;
                start_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input vec_t v);
        conv_lin = v;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit chain, input vec_t next_vec);
        int f0 = frames_done;
        int n = 0;
        while (frames_done == f0 && n < budget) begin
            if (chain && done_exp) begin
                conv_lin = next_vec;
                start = 1'b1;
            end
            cycle();
            start = 1'b0;
            n++;
        end
        check("frame_timeout", 32'(frames_done != f0), 32'd1);
    endtask

    task automatic reset_checks();
        check("rst_valid", 32'(sif.valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(sif.data), 32'd0);
        check("rst_idx", 32'(sif.idx), 32'd0);
        check("rst_last", 32'(sif.last), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        reset_checks();
        exp_q.delete();
        act = 1'b0;
        done_exp = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        sif.ready = 1'b0;
        #2;
        apply_reset();

        // Idle with random data and no start
        ready_mode = 2;
        conv_lin = rand_vec();
        repeat (10) cycle();

        // Full-rate ramp frame
        ready_mode = 0;
        start_frame(ramp_vec());
        run_until_done(400, 1'b0, '0);
        check("latency", 32'(done_cyc - start_cyc), 32'(FRAME_LEN + 1));
        check("frame_last_idx", 32'(last_idx), 32'(FRAME_LEN - 1));

        // Backpressure 1,0,0,1
        ready_mode = 1;
        start_frame(rand_vec());
        run_until_done(800, 1'b0, '0);

        // Capture isolation: input changes and a second start mid-frame
        ready_mode = 0;
        start_frame(rand_vec());
        conv_lin = '1;
        repeat (5) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_until_done(400, 1'b0, '0);

        // Mid-frame reset after 50 transfers, then a clean frame
        start_frame(rand_vec());
        repeat (50) cycle();
        check("xfers_before_reset", 32'(rx), 32'd50);
        apply_reset();
        start_frame(rand_vec());
        run_until_done(400, 1'b0, '0);
        check("post_reset_len", 32'(rx), 32'(FRAME_LEN));

        // Constant 0x03 frames, second one started in the done cycle
        start_frame(const_vec(8'h03));
        run_until_done(400, 1'b1, const_vec(8'h03));
`ifdef STREAM_CHKSUM_EN
        check("chk_data_a", 32'(last_data), 32'h44);
        check("chk_idx_a", 32'(last_idx), 32'd108);
`else
        check("end_data_a", 32'(last_data), 32'h03);
        check("end_idx_a", 32'(last_idx), 32'd107);
`endif
        check("b2b_accepted", 32'(act), 32'd1);
        ready_mode = 2;
        run_until_done(800, 1'b0, '0);
`ifdef STREAM_CHKSUM_EN
        check("chk_data_b", 32'(last_data), 32'h44);
        check("chk_idx_b", 32'(last_idx), 32'd108);
`else
        check("end_data_b", 32'(last_data), 32'h03);
        check("end_idx_b", 32'(last_idx), 32'd107);
`endif

        // Random frames under random backpressure
        for (int f = 0; f < 3; f++) begin
            start_frame(rand_vec());
            run_until_done(1000, 1'b0, '0);
        end
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Sequential unpacker on the output side of the conv datapath.
- Captures the flattened convolution result vector (6x6 output, 3 channels, 8-bit, 108 bytes) in one snapshot.
- Emits the captured result as a byte stream over a valid/ready handshake, in the same byte order the result file writer uses.
- Downstream sinks are the result memory/writer or an off-chip link, so conv_lin never crosses a wide boundary.

Parameters:
- N_BYTES, 108, number of bytes in the result vector (6*6*3).
- W, 8, bits per element.
- IDX_W, 7, width of the byte-index output; must satisfy 2^IDX_W > N_BYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  capture request, sampled only in IDLE.
- conv_lin  input  N_BYTES*W  flattened result; element i at bits [i*W +: W].
- busy  output  1  high from capture until the final transfer completes.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  sink accepts the byte this cycle.
- out_data  output  W  current byte.
- out_idx  output  IDX_W  index of the current byte.
- out_last  output  1  current byte is the final byte of the frame.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, capture register=0, busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0.
- States: IDLE, STREAM, plus CHK when STREAM_CHKSUM_EN is defined.
- IDLE:
  - On start=1 at a clock edge, register all of conv_lin, set idx=0, and go to STREAM.
  - busy=1 and out_valid=1 from the next cycle, with out_data = captured byte 0.
  - Capture-to-first-valid latency is 1 cycle.
- STREAM:
  - out_data = captured byte[idx]; out_idx = idx.
  - out_last = (idx == N_BYTES-1) when the checksum feature is compiled out.
  - A transfer occurs in any cycle with out_valid=1 and out_ready=1.
  - On a transfer with idx < N_BYTES-1: idx increments and the next byte is presented the following cycle. Zero-bubble throughput is 1 byte/cycle with out_ready held high.
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
  - On the transfer of byte N_BYTES-1: go to IDLE (or to CHK if the feature is compiled in). In the IDLE case, out_valid, busy and out_last fall the next cycle, and done=1 for exactly that cycle.
- Ignored inputs: start is ignored while busy=1. conv_lin changes after capture do not affect the stream.
- Back-to-back frames: start asserted in the cycle done=1 (state IDLE) is accepted, so the next frame's first byte is valid one cycle later.
- out_ready may be high while out_valid=0; this has no effect.
- Reset asserted mid-frame: the frame is aborted immediately, all outputs return to reset values, and no done pulse is produced.
- Width rule: out_idx is idx zero-extended to IDX_W; idx never exceeds N_BYTES (N_BYTES only in CHK).

Optional Feature:
- Macro STREAM_CHKSUM_EN.
- When defined:
  - A W-bit running sum (mod 2^W) of all transferred data bytes is accumulated.
  - After byte N_BYTES-1 transfers, the block enters CHK and presents one extra byte: out_data = checksum, out_idx = N_BYTES, out_last = 1.
  - out_last is 0 on byte N_BYTES-1.
  - The CHK byte follows the same hold rules under backpressure.
  - When it transfers: go to IDLE, done pulses, and the sum clears.
- When not defined: no checksum register, no CHK state, and the frame is exactly N_BYTES bytes.

Test Plan:
- Reset then idle: conv_lin=random, start=0 for 10 cycles -> out_valid=0, busy=0, done=0 throughout.
- Full-rate frame: conv_lin byte i = i, start pulse, out_ready=1 -> bytes 0..107 on consecutive cycles, out_idx=0..107, out_last only at idx 107, done one cycle after the idx-107 transfer, 109 cycles start-to-done.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly -> no byte dropped or duplicated; data/idx stable during ready=0; received sequence equals captured vector.
- Capture isolation: start, then conv_lin changed to all 0xFF on the next cycle and start pulsed again mid-frame -> the stream still carries the original vector; the second start is ignored.
- Mid-frame reset: rst_n low after 50 transfers -> outputs zero at once; after release, a new start streams a full 108-byte frame from idx 0.
- STREAM_CHKSUM_EN: all bytes 0x03 -> 109 transfers, final byte out_idx=108, out_data = 108*3 mod 256 = 0x44, out_last=1; back-to-back second frame checksum restarts from 0.
